// File: rtl/gh_report_tx.sv
// gh_report_tx: serialises one 16-bit guitar report frame per Req.
// Frame: {Tilt, Strum, Frets[4:0], Whammy[7:0], check}, sent MSB first.
// Each bit period is CLK_DIV cycles of SClk low, then CLK_DIV cycles of SClk high.
// A CLK_DIV-cycle idle gap follows the last bit, then Done pulses for one cycle.
// Optional feature: define GH_REPORT_PARITY_EN to make the check bit the
// even parity of bits 15:1. When it is undefined the check bit is 0.
// Frame timing is identical in both builds.
module gh_report_tx #(
    parameter int CLK_DIV = 8
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [4:0] Frets,
    input  logic       Strum,
    input  logic [7:0] Whammy,
    input  logic       Tilt,
    input  logic       Req,
    output logic       Busy,
    output logic       Done,
    output logic       SClk,
    output logic       SData,
    output logic       SFrame
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // The divider counts half-periods, so 8 bits covers CLK_DIV up to 255.
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [4:0] BIT_LAST = 5'd15;

    state_t      state, state_nx;
    logic [7:0]  div_cnt, div_nx;
    logic [4:0]  bit_cnt, bit_nx;
    logic [15:0] shreg, shreg_nx;
    logic        sclk_r, sclk_nx;
    logic        busy_r, busy_nx;
    logic        done_r, done_nx;
    logic        sframe_r, sframe_nx;
    logic [15:0] frame_cap;
    logic        div_end;

    // Assemble the frame that is loaded when a request is accepted.
    always_comb begin
        frame_cap = {Tilt, Strum, Frets, Whammy, 1'b0};
`ifdef GH_REPORT_PARITY_EN
        frame_cap[0] = ^frame_cap[15:1];
`else
        frame_cap[0] = 1'b0;
`endif
    end

    assign div_end = (div_cnt == DIV_LAST);

    // Compute the next state and all registered outputs.
    always_comb begin
        state_nx  = state;
        div_nx    = div_cnt;
        bit_nx    = bit_cnt;
        shreg_nx  = shreg;
        sclk_nx   = sclk_r;
        busy_nx   = busy_r;
        done_nx   = 1'b0;
        sframe_nx = sframe_r;
        case (state)
            IDLE: begin
                // Requests are only seen here, so Req is ignored while Busy is high.
                if (Req) begin
                    state_nx  = SHIFT;
                    shreg_nx  = frame_cap;
                    div_nx    = 8'd0;
                    bit_nx    = 5'd0;
                    sclk_nx   = 1'b0;
                    busy_nx   = 1'b1;
                    sframe_nx = 1'b1;
                end
            end
            SHIFT: begin
                if (!div_end) begin
                    div_nx = div_cnt + 8'd1;
                end else begin
                    div_nx = 8'd0;
                    if (!sclk_r) begin
                        // Rising SClk: the receiver samples here and data holds.
                        sclk_nx = 1'b1;
                    end else if (bit_cnt == BIT_LAST) begin
                        // The last bit period is over. Park the line and enter the gap.
                        state_nx  = GAP;
                        shreg_nx  = 16'd0;
                        sframe_nx = 1'b0;
                    end else begin
                        // Falling SClk: this is the only point where SData moves.
                        sclk_nx  = 1'b0;
                        shreg_nx = {shreg[14:0], 1'b0};
                        bit_nx   = bit_cnt + 5'd1;
                    end
                end
            end
            GAP: begin
                if (!div_end) begin
                    div_nx = div_cnt + 8'd1;
                end else begin
                    div_nx   = 8'd0;
                    bit_nx   = 5'd0;
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                end
            end
            default: begin
                state_nx  = IDLE;
                shreg_nx  = 16'd0;
                sclk_nx   = 1'b1;
                busy_nx   = 1'b0;
                sframe_nx = 1'b0;
            end
        endcase
    end

    // State and output registers. Reset leaves the line idle without needing a clock edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            div_cnt  <= 8'd0;
            bit_cnt  <= 5'd0;
            shreg    <= 16'd0;
            sclk_r   <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            sframe_r <= 1'b0;
        end else begin
            state    <= state_nx;
            div_cnt  <= div_nx;
            bit_cnt  <= bit_nx;
            shreg    <= shreg_nx;
            sclk_r   <= sclk_nx;
            busy_r   <= busy_nx;
            done_r   <= done_nx;
            sframe_r <= sframe_nx;
        end
    end

    assign Busy   = busy_r;
    assign Done   = done_r;
    assign SClk   = sclk_r;
    assign SData  = shreg[15];
    assign SFrame = sframe_r;

endmodule

// File: tb/tb_gh_report_tx.sv
// Bench for gh_report_tx with CLK_DIV = 8.
// Outputs are sampled on the falling clock edge.
// The expected frame comes from the field layout. Expected timing comes from CLK_DIV.
module tb_gh_report_tx;

    localparam int D     = 8;
    localparam int T_DONE = 33 * D + 1;

    logic       CLK   = 1'b0;
    logic       RST_N = 1'b1;
    logic [4:0] Frets = '0;
    logic       Strum = 1'b0;
    logic [7:0] Whammy = '0;
    logic       Tilt  = 1'b0;
    logic       Req   = 1'b0;
    logic       Busy, Done, SClk, SData, SFrame;

    int total = 0;
    int bad   = 0;

    gh_report_tx #(.CLK_DIV(D)) dut (
        .CLK(CLK), .RST_N(RST_N), .Frets(Frets), .Strum(Strum), .Whammy(Whammy),
        .Tilt(Tilt), .Req(Req), .Busy(Busy), .Done(Done), .SClk(SClk),
        .SData(SData), .SFrame(SFrame)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame built from the field list. The check bit counts ones.
    function automatic logic [15:0] model(input logic t, input logic s,
                                          input logic [4:0] f, input logic [7:0] w);
        logic [15:0] fr;
        fr = 16'd0;
        fr[15] = t;
        fr[14] = s;
        for (int i = 0; i < 5; i++) fr[9 + i] = f[i];
        for (int i = 0; i < 8; i++) fr[1 + i] = w[i];
`ifdef GH_REPORT_PARITY_EN
        fr[0] = ($countones(fr[15:1]) % 2) == 1;
`endif
        return fr;
    endfunction

    task automatic rand_inputs();
        Frets  = 5'($urandom);
        Strum  = 1'($urandom);
        Whammy = 8'($urandom);
        Tilt   = 1'($urandom);
    endtask

    // mode 0: plain frame. mode 1: Req pulsed mid-frame. mode 2: inputs changed mid-frame.
    task automatic run_frame(input string tag, input logic [15:0] exp, input int mode);
        int done_at = 0, done_cnt = 0, sf_cnt = 0, lo_cnt = 0, nbits = 0;
        logic [15:0] rx = '0;
        logic prev = 1'b1;
        Req = 1'b1;
        @(negedge CLK);
        Req = 1'b0;
        for (int n = 1; n <= T_DONE + 12; n++) begin
            if (n == 1) begin
                chk({tag, " busy_rise"}, Busy, 1);
                chk({tag, " sframe_rise"}, SFrame, 1);
                chk({tag, " sclk_first_low"}, SClk, 0);
            end
            if (SFrame) begin
                sf_cnt++;
                if (!SClk) lo_cnt++;
            end
            if (SClk && !prev && SFrame) begin
                rx = {rx[14:0], SData};
                nbits++;
            end
            if (Done) begin
                done_cnt++;
                if (done_at == 0) done_at = n;
                chk({tag, " busy_low_at_done"}, Busy, 0);
            end
            if (n == T_DONE - 1) chk({tag, " busy_before_done"}, Busy, 1);
            if (n == T_DONE - 2) begin
                chk({tag, " gap_sclk"}, SClk, 1);
                chk({tag, " gap_sdata"}, SData, 0);
            end
            prev = SClk;
            if (mode == 1 && n == 100) Req = 1'b1;
            if (mode == 1 && n == 101) Req = 1'b0;
            if (mode == 2 && n == 50) rand_inputs();
            @(negedge CLK);
        end
        chk({tag, " frame"}, rx, exp);
        chk({tag, " nbits"}, nbits, 16);
        chk({tag, " sframe_cycles"}, sf_cnt, 32 * D);
        chk({tag, " sclk_low_cycles"}, lo_cnt, 16 * D);
        chk({tag, " done_cycle"}, done_at, T_DONE);
        chk({tag, " done_count"}, done_cnt, 1);
    endtask

    // Req held high: the frames run back to back with a single idle cycle between them.
    task automatic run_b2b(input logic [15:0] exp);
        int d1 = 0, d2 = 0, dcnt = 0, nbits = 0;
        logic [31:0] rx = '0;
        logic prev = 1'b1;
        Req = 1'b1;
        @(negedge CLK);
        for (int n = 1; n <= 2 * T_DONE + 10; n++) begin
            if (SClk && !prev && SFrame) begin
                rx = {rx[30:0], SData};
                nbits++;
            end
            if (Done) begin
                dcnt++;
                if (d1 == 0) d1 = n;
                else if (d2 == 0) d2 = n;
            end
            if (n == T_DONE) chk("b2b busy_gap", Busy, 0);
            if (n == T_DONE + 1) chk("b2b busy_restart", Busy, 1);
            prev = SClk;
            if (n == T_DONE + 40) Req = 1'b0;
            @(negedge CLK);
        end
        chk("b2b done1", d1, T_DONE);
        chk("b2b done2", d2, 2 * T_DONE);
        chk("b2b done_count", dcnt, 2);
        chk("b2b nbits", nbits, 32);
        chk("b2b frames", rx, {exp, exp});
    endtask

    initial begin
        logic [15:0] exp;
        #1 RST_N = 1'b0;
        #1;
        chk("reset busy", Busy, 0);
        chk("reset done", Done, 0);
        chk("reset sclk", SClk, 1);
        chk("reset sdata", SData, 0);
        chk("reset sframe", SFrame, 0);
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);

        // Known frame. Its ones count is even, so both builds give the same value.
        Frets = 5'b10101; Strum = 1'b1; Whammy = 8'hA5; Tilt = 1'b0;
        run_frame("known", 16'h6B4A, 0);

        Frets = 5'd0; Strum = 1'b0; Whammy = 8'd0; Tilt = 1'b1;
`ifdef GH_REPORT_PARITY_EN
        run_frame("tilt_only", 16'h8001, 0);
`else
        run_frame("tilt_only", 16'h8000, 0);
`endif

        for (int k = 0; k < 3; k++) begin
            rand_inputs();
            run_frame("random", model(Tilt, Strum, Frets, Whammy), 0);
        end

        rand_inputs();
        run_frame("mid_req", model(Tilt, Strum, Frets, Whammy), 1);

        rand_inputs();
        exp = model(Tilt, Strum, Frets, Whammy);
        run_frame("input_change", exp, 2);

        rand_inputs();
        run_b2b(model(Tilt, Strum, Frets, Whammy));

        // Assert reset in the middle of bit 7. The line must go idle before any clock edge.
        rand_inputs();
        Req = 1'b1;
        @(negedge CLK);
        Req = 1'b0;
        repeat (7 * 2 * D + 4) @(negedge CLK);
        #1 RST_N = 1'b0;
        #1;
        chk("midrst busy", Busy, 0);
        chk("midrst sclk", SClk, 1);
        chk("midrst sdata", SData, 0);
        chk("midrst sframe", SFrame, 0);
        chk("midrst done", Done, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("midrst no_done", Done, 0);
        end
        RST_N = 1'b1;
        @(negedge CLK);
        chk("postrst idle", Busy, 0);
        rand_inputs();
        run_frame("after_reset", model(Tilt, Strum, Frets, Whammy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gh_report_tx.md
GH_REPORT_TX -- requirements
Module: gh_report_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 8, giving the SClk half-period in CLK cycles; legal range 2..255.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock for all logic.
REQ-003 SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port Frets, input, 5 bits: fret state from the player stage, {O,B,Y,R,G}.
REQ-005 SHALL have port Strum, input, 1 bit: strum state from the player stage.
REQ-006 SHALL have port Whammy, input, 8 bits: whammy value from the player stage.
REQ-007 SHALL have port Tilt, input, 1 bit: tilt state from the player stage.
REQ-008 SHALL have port Req, input, 1 bit: request to send one report frame.
REQ-009 SHALL have port Busy, output, 1 bit: a frame is in progress.
REQ-010 SHALL have port Done, output, 1 bit: one-cycle pulse when a frame completes.
REQ-011 SHALL have port SClk, output, 1 bit: serial clock, idle high.
REQ-012 SHALL have port SData, output, 1 bit: serial data, MSB first.
REQ-013 SHALL have port SFrame, output, 1 bit: high while frame bits are on the line.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, GAP.
REQ-015 SHALL, in IDLE with Req=1 at a rising CLK edge, capture all inputs into a 16-bit shift register, set Busy=1 and SFrame=1, and enter SHIFT; outputs change in the cycle after Req.
REQ-016 SHALL use this frame layout: bit15 Tilt; bit14 Strum; bits13:9 Frets[4:0]; bits8:1 Whammy[7:0]; bit0 check bit (see Configuration).
REQ-017 SHALL give each bit period 2*CLK_DIV cycles: SClk low for the first CLK_DIV cycles and high for the second CLK_DIV cycles; SData changes only on the SClk falling transition (receiver samples on the rising transition).
REQ-018 SHALL drive SData with bit15 during the first bit period and shift left once per bit period; a 16-bit counter-driven frame lasts exactly 32*CLK_DIV cycles.
REQ-019 SHALL, after the last bit period, drop SFrame to 0, set SClk=1 and SData=0, and enter GAP for CLK_DIV cycles.
REQ-020 SHALL, at the end of GAP, pulse Done for exactly one cycle, drop Busy to 0 in that same cycle, and return to IDLE; Done occurs 33*CLK_DIV+1 cycles after the Req cycle.
REQ-021 SHALL ignore Req while Busy=1 (no queueing); Req held high continuously SHALL start a new frame on the first IDLE cycle after Done, giving back-to-back frames.
REQ-022 SHALL leave frame contents unaffected by input changes after capture.
REQ-023 SHALL size the divider counter at 8 bits and the bit counter at 5 bits; neither counter SHALL wrap within a frame.

Reset
REQ-024 SHALL, on RST_N=0 (asynchronous, including mid-frame), force IDLE with Busy=0, Done=0, SClk=1, SData=0, SFrame=0, and clear the counters and shift register.
REQ-025 SHALL accept no Req until the first rising CLK edge after RST_N deasserts.

Configuration
REQ-026 SHALL, when macro GH_REPORT_PARITY_EN is defined, set bit0 to even parity: the XOR of bits15:1.
REQ-027 SHALL, when GH_REPORT_PARITY_EN is undefined, set bit0 to constant 0; all timing SHALL be identical either way.

Verification
REQ-028 SHALL cover this case: Frets=5'b10101, Strum=1, Whammy=8'hA5, Tilt=0, Req pulse -> sampled frame 16'h6B4A (both macro settings).
REQ-029 SHALL cover this case: Tilt=1, all other inputs 0 -> frame 16'h8001 with GH_REPORT_PARITY_EN and 16'h8000 without.
REQ-030 SHALL cover this case: CLK_DIV=8, single Req -> Busy rises 1 cycle later, Done pulse exactly 265 cycles after the Req cycle, and SFrame high for 256 cycles.
REQ-031 SHALL cover this case: Req pulsed mid-frame -> no effect on the frame and only one Done; Req held high -> back-to-back frames separated by exactly 1 IDLE cycle.
REQ-032 SHALL cover this case: RST_N asserted at bit 7 of a frame -> outputs idle immediately (no clock edge required) and no Done; a Req after release -> complete correct frame.
REQ-033 SHALL cover this case: inputs change during SHIFT -> frame equals the values captured at Req.
